alu_shift_sequencer: RTL and testbench

- Multi-cycle controller that drives the team's N-bit single-step shifter (alu_shift_1bit) to shift an operand by an arbitrary amount.
- Latches an operand, operation and amount on a start strobe, then feeds the shifter output back into its input once per clock until the amount is consumed.
- Reports the result with a one-cycle done pulse.
- The shifter itself is external. This block owns only the sequencing, the accumulator and the handshake.

---
 rtl/alu_shift_sequencer.sv | 100 ++++++++++
 tb/tb_alu_shift_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer
// Multi-cycle controller for an external single-step shifter (alu_shift_1bit).
// It latches an operand, an operation and a step count on start. It then loops
// the shifter result back into its accumulator once per clock until the count
// reaches zero. The result is reported with a one-cycle done pulse.
module alu_shift_sequencer #(
    parameter int N  = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  a_in,
    input  logic [1:0]    op,
    input  logic [AW-1:0] amt,
    output logic [N-1:0]  sh_a,
    output logic [1:0]    sh_s,
    input  logic [N-1:0]  sh_z,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  z_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    state_e        state_q;
    logic [N-1:0]  acc_q;
    logic [1:0]    op_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  z_q;

    // Sequencer FSM: the state, the datapath registers and the registered busy/done flags.
    always_ff @(posedge clk) begin
        // NOTE: all state here is updated with non-blocking assignments, so every
        // right-hand side reads the pre-edge value and statement order does not matter.
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op_q    <= 2'b00;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q  <= a_in;
                        op_q   <= op;
                        cnt_q  <= amt;
                        busy_q <= 1'b1;
                        if (amt != '0) begin
                            state_q <= S_SHIFT;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    // SHIFT is only entered with cnt_q >= 1, so the decrement cannot wrap.
                    acc_q <= sh_z;
                    cnt_q <= cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    z_q     <= acc_q;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Shifter drive and handshake outputs.
    // NOTE: during DONE the final accumulator is bypassed onto z_out. The result
    // is then valid in the same cycle as the done pulse, one edge before z_q
    // captures it.
    assign sh_a  = acc_q;
    assign sh_s  = op_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign z_out = done_q ? acc_q : z_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer (N=4, AW=3).
// A behavioural stand-in for alu_shift_1bit closes the sh_a/sh_s -> sh_z loop.
module tb_alu_shift_sequencer;

    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  a_in;
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic [N-1:0]  sh_a;
    logic [1:0]    sh_s;
    logic [N-1:0]  sh_z;
    logic          busy;
    logic          done;
    logic [N-1:0]  z_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic [N-1:0] exp_q[$];

    alu_shift_sequencer #(.N(N), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .op    (op),
        .amt   (amt),
        .sh_a  (sh_a),
        .sh_s  (sh_s),
        .sh_z  (sh_z),
        .busy  (busy),
        .done  (done),
        .z_out (z_out)
    );

    always #5 clk = ~clk;

    // Single combinational step of the external shifter.
    function automatic logic [N-1:0] step(input logic [N-1:0] a, input logic [1:0] s);
        case (s)
            2'b00:   return {a[N-2:0], 1'b0};
            2'b01:   return {1'b0, a[N-1:1]};
            2'b10:   return {a[N-1], a[N-1:1]};
            default: return {a[N-2:0], a[N-1]};
        endcase
    endfunction

    assign sh_z = step(sh_a, sh_s);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to its done pulse. The shifter input is
    // checked on every SHIFT cycle, and the latency and result are checked on
    // done. If poke > 0, a conflicting start is pulsed in that cycle to show
    // that it is ignored while busy.
    task automatic do_op(input logic [N-1:0] a, input logic [1:0] o,
                         input logic [AW-1:0] m, input logic [N-1:0] exp_z,
                         input int poke);
        logic [N-1:0] acc;
        logic [N-1:0] want;
        int cyc;
        bit seen;
        acc  = a;
        want = '0;
        cyc  = 0;
        seen = 1'b0;
        exp_q.push_back(exp_z);
        start = 1'b1;
        a_in  = a;
        op    = o;
        amt   = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 4'($urandom);
        op    = 2'($urandom);
        amt   = 3'($urandom);
        while (cyc < 40 && !seen) begin
            cyc++;
            @(negedge clk);
            if (start) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                want = exp_q.pop_front();
                check("latency", cyc, int'(m) + 1);
                check("z_out", z_out, want);
                check("busy_at_done", busy, 1);
            end else begin
                check("busy", busy, 1);
                if (cyc <= int'(m)) begin
                    check("sh_a", sh_a, acc);
                    check("sh_s", sh_s, o);
                    acc = step(acc, o);
                end
                if (cyc == poke) begin
                    start = 1'b1;
                    a_in  = 4'b0001;
                    op    = 2'b00;
                    amt   = 3'd1;
                end
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end else begin
            // A start raised in the DONE cycle must not be accepted.
            start = 1'b1;
            a_in  = 4'hF;
            amt   = '0;
            @(negedge clk);
            start = 1'b0;
            check("start_in_done_ignored", busy, 0);
            check("done_one_cycle", done, 0);
            check("z_hold", z_out, want);
        end
    endtask

    // Abort an operation with rst during SHIFT.
    task automatic abort_op();
        bit saw;
        saw   = 1'b0;
        start = 1'b1;
        a_in  = 4'b1011;
        op    = 2'b11;
        amt   = 3'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_z_out", z_out, 4'b0000);
        check("abort_sh_a", sh_a, 4'b0000);
        check("abort_sh_s", sh_s, 2'b00);
        repeat (12) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("no_done_after_abort", saw, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        op    = 2'b00;
        amt   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_z_out", z_out, 4'b0000);
        check("rst_sh_a", sh_a, 4'b0000);
        check("rst_sh_s", sh_s, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        do_op(4'b1011, 2'b00, 3'd2, 4'b1100, 0);  // SLL by 2
        do_op(4'b1011, 2'b10, 3'd1, 4'b1101, 0);  // SRA by 1
        do_op(4'b1011, 2'b11, 3'd3, 4'b1101, 0);  // ROL by 3
        do_op(4'b1111, 2'b01, 3'd5, 4'b0000, 0);  // SRL past width
        do_op(4'b1010, 2'b00, 3'd0, 4'b1010, 0);  // zero amount
        do_op(4'b1011, 2'b11, 3'd5, 4'b0111, 2);  // ROL 5 == ROL 1, start poked mid-SHIFT
        do_op(4'b1001, 2'b10, 3'd6, 4'b1111, 0);  // SRA past width -> sign fill
        do_op(4'b0001, 2'b00, 3'd7, 4'b0000, 0);  // SLL by max amount
        do_op(4'b1001, 2'b11, 3'd7, 4'b1100, 0);  // ROL 7 == ROL 3
        do_op(4'b0110, 2'b10, 3'd2, 4'b0001, 0);  // SRA positive value
        abort_op();
        do_op(4'b0101, 2'b01, 3'd1, 4'b0010, 0);  // recovery after abort

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
